// File: rtl/hash_mem_responder.sv
// hash_mem_responder: word memory shared by a bus initiator and a host, with a result-window write collector
// Configuration macro: HASH_MEM_OOB_CHECK_EN (addresses >= DEPTH do not write, read 0, set err_oob).
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   mem_we/mem_addr/mem_write_data     initiator write strobe, word address, write data
//   mem_read_data                      registered read-first data for mem_addr
//   load_valid/load_ready              host preload handshake (ready = !mem_we)
//   load_addr/load_data                host preload address and data
//   dump_req/dump_addr                 host readback request and address
//   dump_valid/dump_data               host readback response, one cycle after acceptance
//   arm/res_base                       start a collection over the result window at res_base
//   res_count/res_done/err_oob         result-write count, collection complete, sticky out-of-range flag
module hash_mem_responder #(
    parameter int ADDR_W    = 8,
    parameter int RES_WORDS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_we,
    input  logic [15:0] mem_addr,
    input  logic [31:0] mem_write_data,
    output logic [31:0] mem_read_data,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [15:0] load_addr,
    input  logic [31:0] load_data,
    input  logic        dump_req,
    input  logic [15:0] dump_addr,
    output logic        dump_valid,
    output logic [31:0] dump_data,
    input  logic        arm,
    input  logic [15:0] res_base,
    output logic [7:0]  res_count,
    output logic        res_done,
    output logic        err_oob
);
    localparam int DEPTH = 1 << ADDR_W;
    typedef enum logic [1:0] {IDLE, ARMED, COLLECT, COMPLETE} state_t;
    logic [31:0]       r_mem [DEPTH];
    state_t            r_state;
    logic              w_load_fire, w_dump_fire, w_we, w_res_hit;
    logic              w_bus_ok, w_load_ok, w_dump_ok;
    logic [ADDR_W-1:0] w_waddr;
    logic [31:0]       w_wdata;
    logic [7:0]        w_cnt_nxt;
    logic [16:0]       w_res_end;
`ifdef HASH_MEM_OOB_CHECK_EN
    localparam logic [16:0] DEPTH_L = 17'(DEPTH);
    logic r_err;
    assign w_bus_ok  = {1'b0, mem_addr} < DEPTH_L;
    assign w_load_ok = {1'b0, load_addr} < DEPTH_L;
    assign w_dump_ok = {1'b0, dump_addr} < DEPTH_L;
    // The bus port reads every cycle, so its address is checked every cycle.
    always_ff @(posedge clk) begin
        if (reset)
            r_err <= 1'b0;
        else if (!w_bus_ok || (w_load_fire && !w_load_ok) || (w_dump_fire && !w_dump_ok))
            r_err <= 1'b1;
    end
    assign err_oob = r_err;
`else
    logic w_unused;
    assign w_unused  = ^{mem_addr, load_addr, dump_addr};
    assign w_bus_ok  = 1'b1;
    assign w_load_ok = 1'b1;
    assign w_dump_ok = 1'b1;
    assign err_oob   = 1'b0;
`endif
    // The bus owns the write port whenever mem_we is high, so loads and bus writes never collide.
    assign load_ready  = !mem_we;
    assign w_load_fire = load_valid && load_ready;
    assign w_dump_fire = dump_req && !mem_we && !w_load_fire;
    assign w_we        = mem_we ? w_bus_ok : (w_load_fire && w_load_ok);
    assign w_waddr     = mem_we ? mem_addr[ADDR_W-1:0] : load_addr[ADDR_W-1:0];
    assign w_wdata     = mem_we ? mem_write_data : load_data;
    always_ff @(posedge clk) begin
        if (w_we)
            r_mem[w_waddr] <= w_wdata;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_read_data <= 32'h0;
            dump_valid    <= 1'b0;
            dump_data     <= 32'h0;
        end else begin
            mem_read_data <= w_bus_ok ? r_mem[mem_addr[ADDR_W-1:0]] : 32'h0;
            dump_valid    <= w_dump_fire;
            if (w_dump_fire)
                dump_data <= w_dump_ok ? r_mem[dump_addr[ADDR_W-1:0]] : 32'h0;
        end
    end
    // 17-bit window bounds so a window near 16'hFFFF does not wrap to low addresses.
    assign w_res_end = {1'b0, res_base} + 17'(RES_WORDS);
    assign w_res_hit = mem_we && ({1'b0, mem_addr} >= {1'b0, res_base}) && ({1'b0, mem_addr} < w_res_end);
    assign w_cnt_nxt = res_count + 8'd1;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            res_count <= 8'd0;
            res_done  <= 1'b0;
        end else if (arm) begin
            r_state   <= ARMED;
            res_count <= 8'd0;
            res_done  <= 1'b0;
        end else if (w_res_hit && (r_state == ARMED || r_state == COLLECT)) begin
            res_count <= w_cnt_nxt;
            r_state   <= (w_cnt_nxt == 8'(RES_WORDS)) ? COMPLETE : COLLECT;
            res_done  <= (w_cnt_nxt == 8'(RES_WORDS));
        end
    end
endmodule

// File: tb/tb_hash_mem_responder.sv
// tb_hash_mem_responder: scoreboard bench for hash_mem_responder
module tb_hash_mem_responder;
    logic        clk = 1'b0, reset = 1'b1;
    logic        mem_we = 1'b0, load_valid = 1'b0, dump_req = 1'b0, arm = 1'b0;
    logic [15:0] mem_addr = 16'h0, load_addr = 16'h0, dump_addr = 16'h0, res_base = 16'h0;
    logic [31:0] mem_write_data = 32'h0, load_data = 32'h0;
    logic [31:0] mem_read_data, dump_data;
    logic        load_ready, dump_valid, res_done, err_oob;
    logic [7:0]  res_count;
    int          n_vec = 0, n_err = 0;
    logic [31:0] model [256];
    logic [31:0] sb [$];
    logic        exp_err;

    hash_mem_responder dut (
        .clk(clk), .reset(reset),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
        .load_valid(load_valid), .load_ready(load_ready), .load_addr(load_addr), .load_data(load_data),
        .dump_req(dump_req), .dump_addr(dump_addr), .dump_valid(dump_valid), .dump_data(dump_data),
        .arm(arm), .res_base(res_base), .res_count(res_count), .res_done(res_done), .err_oob(err_oob)
    );

    always #5 clk = ~clk;

    function automatic bit oob(input logic [15:0] a);
`ifdef HASH_MEM_OOB_CHECK_EN
        return a >= 16'd256;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] mrd(input logic [15:0] a);
        return oob(a) ? 32'h0 : model[a[7:0]];
    endfunction

    task automatic mwr(input logic [15:0] a, input logic [31:0] d);
        if (!oob(a)) model[a[7:0]] = d;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic bus(input logic we, input logic [15:0] a, input logic [31:0] d);
        mem_we = we;
        mem_addr = a;
        mem_write_data = d;
        sb.push_back(mrd(a));
        if (we) mwr(a, d);
        tick;
        mem_we = 1'b0;
        check("bus_rd", mem_read_data, sb.pop_front());
    endtask

    task automatic dump(input logic [15:0] a);
        dump_req = 1'b1;
        dump_addr = a;
        sb.push_back(mrd(a));
        tick;
        dump_req = 1'b0;
        check("dump_valid", {31'b0, dump_valid}, 32'h1);
        check("dump_data", dump_data, sb.pop_front());
    endtask

    task automatic load(input logic [15:0] a, input logic [31:0] d);
        load_valid = 1'b1;
        load_addr = a;
        load_data = d;
        mwr(a, d);
        tick;
        load_valid = 1'b0;
    endtask

    task automatic cnt(input string tag, input logic [7:0] c, input logic done);
        check(tag, {24'b0, res_count}, {24'b0, c});
        check(tag, {31'b0, res_done}, {31'b0, done});
    endtask

    initial begin
        tick;
        tick;
        check("rst_rd", mem_read_data, 32'h0);
        check("rst_dv", {31'b0, dump_valid}, 32'h0);
        check("rst_dd", dump_data, 32'h0);
        check("rst_err", {31'b0, err_oob}, 32'h0);
        check("rst_lrdy", {31'b0, load_ready}, 32'h1);
        cnt("rst_cnt", 8'd0, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 256; i++) load(16'(i), $urandom);
        for (int i = 0; i < 20; i++) load(16'(i), 32'h1000 + i);
        bus(1'b0, 16'd0, 32'h0);
        check("rd0_const", mem_read_data, 32'h1000);
        bus(1'b0, 16'd1, 32'h0);
        bus(1'b0, 16'd2, 32'h0);
        check("rd2_const", mem_read_data, 32'h1002);
        bus(1'b1, 16'd5, 32'hDEADBEEF);
        check("rfirst_old", mem_read_data, 32'h1005);
        bus(1'b0, 16'd5, 32'h0);
        check("rfirst_new", mem_read_data, 32'hDEADBEEF);
        // load and dump held off by a bus write, dump then dropped by the load
        load_valid = 1'b1; load_addr = 16'd30; load_data = 32'h30303030;
        dump_req = 1'b1; dump_addr = 16'd10;
        mem_we = 1'b1; mem_addr = 16'd40; mem_write_data = 32'h40404040;
        #1;
        check("lrdy_busy", {31'b0, load_ready}, 32'h0);
        sb.push_back(mrd(16'd40));
        mwr(16'd40, 32'h40404040);
        tick;
        check("bus_rd", mem_read_data, sb.pop_front());
        check("dump_drop_we", {31'b0, dump_valid}, 32'h0);
        mem_we = 1'b0;
        #1;
        check("lrdy_free", {31'b0, load_ready}, 32'h1);
        mwr(16'd30, 32'h30303030);
        tick;
        load_valid = 1'b0;
        check("dump_drop_ld", {31'b0, dump_valid}, 32'h0);
        dump_req = 1'b0;
        dump(16'd30);
        dump(16'd40);
        dump(16'd10);
        // full collection
        arm = 1'b1; res_base = 16'h0080;
        tick;
        arm = 1'b0;
        cnt("arm_cnt", 8'd0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            bus(1'b1, 16'h0080 + 16'(i), $urandom);
            cnt("col_cnt", 8'(i + 1), i == 15);
        end
        bus(1'b1, 16'h0090, 32'h90909090);
        cnt("past_win", 8'd16, 1'b1);
        bus(1'b1, 16'h0085, 32'h85858585);
        cnt("complete_hold", 8'd16, 1'b1);
        load(16'h0081, 32'h81818181);
        cnt("load_nocount", 8'd16, 1'b1);
        // reset mid-collection
        arm = 1'b1;
        tick;
        arm = 1'b0;
        cnt("rearm", 8'd0, 1'b0);
        for (int i = 0; i < 7; i++) bus(1'b1, 16'h0080 + 16'(i), 32'hA000 + i);
        cnt("seven", 8'd7, 1'b0);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        cnt("rst_mid", 8'd0, 1'b0);
        bus(1'b1, 16'h0087, 32'h87878787);
        cnt("idle_hold", 8'd0, 1'b0);
        for (int i = 0; i < 7; i++) dump(16'h0080 + 16'(i));
        check("keep80", dump_data, 32'hA006);
        // arm wins over a same-cycle result write
        arm = 1'b1; mem_we = 1'b1; mem_addr = 16'h0081; mem_write_data = 32'h11112222;
        mwr(16'h0081, 32'h11112222);
        tick;
        arm = 1'b0; mem_we = 1'b0;
        cnt("arm_prio", 8'd0, 1'b0);
        bus(1'b1, 16'h0082, 32'h33334444);
        cnt("after_prio", 8'd1, 1'b0);
        // out-of-range / aliasing
        bus(1'b1, 16'h0100, 32'hCAFEF00D);
`ifdef HASH_MEM_OOB_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        check("err_oob", {31'b0, err_oob}, {31'b0, exp_err});
        mem_addr = 16'h0;
        dump(16'h0100);
        dump(16'h0000);
        // window near the top of the address space must not wrap
        arm = 1'b1; res_base = 16'hFFF8;
        tick;
        arm = 1'b0;
        bus(1'b1, 16'h0003, 32'h0BAD0003);
        cnt("nowrap", 8'd0, 1'b0);
        bus(1'b1, 16'hFFFA, 32'h0000FFFA);
        cnt("top_win", 8'd1, 1'b0);
        mem_addr = 16'h0;
        dump(16'h00FA);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/hash_mem_responder.md
HASH_MEM_RESPONDER -- requirements
Module: hash_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning log2 of word depth (DEPTH = 2^ADDR_W 32-bit words).
REQ-002 SHALL have parameter RES_WORDS, default 16, meaning the number of result-window writes that completes a collection.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all ports are sampled and driven on its rising edge.
REQ-004 SHALL have port reset, input, 1, meaning reset; one clock, reset is synchronous and active-high.
REQ-005 SHALL have port mem_we, input, 1, meaning initiator write strobe.
REQ-006 SHALL have port mem_addr, input, 16, meaning initiator word address.
REQ-007 SHALL have port mem_write_data, input, 32, meaning initiator write data.
REQ-008 SHALL have port mem_read_data, output, 32, meaning registered read data to initiator.
REQ-009 SHALL have port load_valid/load_ready, input/output, 1/1, meaning host preload handshake.
REQ-010 SHALL have port load_addr/load_data, input, 16/32, meaning host preload address and data.
REQ-011 SHALL have port dump_req/dump_addr, input, 1/16, meaning host readback request and address.
REQ-012 SHALL have port dump_valid/dump_data, output, 1/32, meaning host readback response.
REQ-013 SHALL have port arm/res_base, input, 1/16, meaning start of a collection and base of the result window.
REQ-014 SHALL have port res_count/res_done/err_oob, output, 8/1/1, meaning result-write count, collection complete, and sticky out-of-range flag.

Function
REQ-015 Bus read SHALL be synchronous read-first: mem_read_data equals mem[mem_addr] as sampled at edge N, valid after edge N+1, every cycle regardless of mem_we.
REQ-016 With mem_we=1, mem[mem_addr] SHALL be written with mem_write_data at the edge; a same-cycle read of that address SHALL return the old value.
REQ-017 load_ready SHALL equal !mem_we (combinational); a load SHALL write on any edge where load_valid && load_ready.
REQ-018 A dump SHALL be accepted when dump_req && !mem_we && !(load_valid && load_ready); dump_valid SHALL pulse one cycle later with dump_data = mem[dump_addr], read-first.
REQ-019 A dump_req that is not accepted SHALL be dropped; the host re-asserts it.
REQ-020 The collector FSM SHALL have the states IDLE, ARMED, COLLECT, and COMPLETE.
REQ-021 arm in any state SHALL move the collector to ARMED and clear res_count and res_done; arm has priority over a same-cycle result write.
REQ-022 A result write is a bus write with res_base <= mem_addr < res_base+RES_WORDS, using 17-bit compare with no wrap past 16'hFFFF.
REQ-023 In ARMED, a result write SHALL move the collector to COLLECT; in ARMED or COLLECT, each result write SHALL increment res_count.
REQ-024 When res_count reaches RES_WORDS, the collector SHALL enter COMPLETE and set res_done=1 from the same edge that stores the final write.
REQ-025 In COMPLETE and IDLE, res_count SHALL hold; further writes still update memory.
REQ-026 Host loads SHALL never count as result writes.

Reset
REQ-027 On reset at a clock edge: state=IDLE, mem_read_data=0, dump_valid=0, dump_data=0, res_count=0, res_done=0, and err_oob=0.
REQ-028 Memory contents SHALL be preserved across reset.
REQ-029 Reset mid-collection SHALL abandon the collection; a new arm is required.

Configuration
REQ-030 With HASH_MEM_OOB_CHECK_EN defined, any bus, load, or dump address >= DEPTH SHALL not write, SHALL read as 32'h0, and SHALL set err_oob sticky until reset.
REQ-031 Without HASH_MEM_OOB_CHECK_EN, addresses SHALL alias modulo DEPTH (upper bits ignored) and err_oob SHALL be tied 0.

Verification
REQ-032 Load addr 0..19 with data 32'h1000+i, then bus reads at addr 0,1,2 on consecutive cycles SHALL give mem_read_data 32'h1000, 32'h1001, 32'h1002 one cycle after each address.
REQ-033 Bus write addr 5 with 32'hDEADBEEF while reading addr 5 in the same cycle SHALL return the old value, and SHALL return 32'hDEADBEEF the next cycle.
REQ-034 arm with res_base=16'h0080, then 16 bus writes to 0x80..0x8F SHALL give res_count stepping 1..16 and res_done=1 after the 16th edge; a write to 0x90 SHALL leave res_count=16.
REQ-035 load_valid held during a mem_we=1 cycle SHALL give load_ready=0 with no load write, and the load SHALL complete the next cycle when mem_we=0.
REQ-036 Reset asserted after 7 result writes SHALL give res_count=0 and res_done=0; memory at 0x80..0x86 SHALL retain its data via dump.
REQ-037 With the macro defined, a write to addr 16'h0100 (DEPTH=256) SHALL set err_oob=1 and a dump of 0x0100 SHALL return 0; without the macro, the same write SHALL land at addr 0.
